// File: rtl/paddle_ctrl_p.sv
// Paddle controller for the single-player pong datapath.
// Keeps the paddle's left-edge x on a fixed screen row and moves it once per
// divided movement tick from the active-low board keys, saturating at the
// bounds. Every move or restart streams an erase pass over the old span and a
// draw pass over the new span to the plotter over a valid/ready handshake.
// Optional build macro: PADDLE_ACCEL_EN doubles the step after a sustained
// same-direction hold (8th consecutive accepted tick onward).
module paddle_ctrl_p #(
    parameter int PAD_W    = 25,
    parameter int X_MIN    = 15,
    parameter int X_MAX    = 103,
    parameter int X_START  = 60,
    parameter int Y_ROW    = 119,
    parameter int TICK_DIV = 1250000,
    parameter int STEP     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       game_over,
    input  logic [6:0] ball_y,
    output logic [7:0] paddle_x,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] colour,
    output logic       plot_valid,
    input  logic       plot_ready,
    output logic       busy
);

    localparam int                 CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [5:0]         IDX_LAST  = 6'(PAD_W - 1);
    localparam logic signed [8:0]  X_MIN_S   = 9'(X_MIN);
    localparam logic signed [8:0]  X_MAX_S   = 9'(X_MAX);
    localparam logic [7:0]         X_MIN_8   = 8'(X_MIN);
    localparam logic [7:0]         X_MAX_8   = 8'(X_MAX);
    localparam logic [7:0]         X_START_8 = 8'(X_START);
    localparam logic [6:0]         Y_ROW_7   = 7'(Y_ROW);
    localparam logic [2:0]         COL_ERASE = 3'b000;
    localparam logic [2:0]         COL_DRAW  = 3'b111;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ERASE = 2'd2,
        ST_DRAW  = 2'd3
    } state_t;

    logic [CNT_W-1:0]  tick_cnt_r;
    logic              tick_s;
    state_t            state_r;
    logic [5:0]        idx_r;
    logic [5:0]        idx_nxt_s;
    logic [7:0]        old_x_r;
    logic              pending_r;
    logic              restart_req_s;
    logic              move_left_s;
    logic              move_right_s;
    logic signed [8:0] step_s;
    logic signed [8:0] cand_s;
    logic [7:0]        new_x_s;
    logic              move_go_s;

`ifdef PADDLE_ACCEL_EN
    logic [2:0]        hold_cnt_r;
    logic              hold_dir_r;
`endif

    // Decode keys, pick the step size, and compute the saturated target x.
    always_comb begin
        move_left_s  = (key_left == 1'b0) && (key_right == 1'b1);
        move_right_s = (key_left == 1'b1) && (key_right == 1'b0);
`ifdef PADDLE_ACCEL_EN
        if ((hold_cnt_r == 3'd7) && (hold_dir_r == move_right_s)) begin
            step_s = 9'(2 * STEP);
        end else begin
            step_s = 9'(STEP);
        end
`else
        step_s = 9'(STEP);
`endif
        cand_s  = $signed({1'b0, paddle_x});
        new_x_s = paddle_x;
        if (move_left_s) begin
            cand_s = $signed({1'b0, paddle_x}) - step_s;
            if (cand_s < X_MIN_S) begin
                new_x_s = X_MIN_8;
            end else begin
                new_x_s = cand_s[7:0];
            end
        end else if (move_right_s) begin
            cand_s = $signed({1'b0, paddle_x}) + step_s;
            if (cand_s > X_MAX_S) begin
                new_x_s = X_MAX_8;
            end else begin
                new_x_s = cand_s[7:0];
            end
        end else begin
            new_x_s = paddle_x;
        end
    end

    // Tick, restart and move qualification; ticks outside IDLE are dropped.
    always_comb begin
        tick_s        = (tick_cnt_r == TICK_LAST);
        restart_req_s = game_over && (ball_y > 7'd115);
        idx_nxt_s     = idx_r + 6'd1;
        move_go_s     = tick_s && (state_r == ST_IDLE) &&
                        (move_left_s || move_right_s) && (new_x_s != paddle_x);
    end

    // Free-running movement tick divider.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
        end
    end

    // Remember a restart request until the FSM is free to act on it.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if (restart_req_s) begin
            pending_r <= 1'b1;
        end else if (state_r == ST_IDLE) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Redraw FSM: owns paddle position and all registered plot outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_INIT;
            idx_r      <= 6'd0;
            old_x_r    <= X_START_8;
            paddle_x   <= X_START_8;
            plot_x     <= 8'd0;
            plot_y     <= Y_ROW_7;
            colour     <= COL_ERASE;
            plot_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            plot_y <= Y_ROW_7;
            case (state_r)
                ST_INIT: begin
                    // Screen is blank after reset, so go straight to drawing.
                    idx_r      <= 6'd0;
                    state_r    <= ST_DRAW;
                    plot_x     <= paddle_x;
                    colour     <= COL_DRAW;
                    plot_valid <= 1'b1;
                    busy       <= 1'b1;
                end
                ST_IDLE: begin
                    if (pending_r) begin
                        old_x_r    <= paddle_x;
                        paddle_x   <= X_START_8;
                        idx_r      <= 6'd0;
                        state_r    <= ST_ERASE;
                        plot_x     <= paddle_x;
                        colour     <= COL_ERASE;
                        plot_valid <= 1'b1;
                        busy       <= 1'b1;
                    end else if (move_go_s) begin
                        old_x_r    <= paddle_x;
                        paddle_x   <= new_x_s;
                        idx_r      <= 6'd0;
                        state_r    <= ST_ERASE;
                        plot_x     <= paddle_x;
                        colour     <= COL_ERASE;
                        plot_valid <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        plot_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                ST_ERASE: begin
                    if (plot_valid && plot_ready) begin
                        if (idx_r == IDX_LAST) begin
                            state_r <= ST_DRAW;
                            idx_r   <= 6'd0;
                            plot_x  <= paddle_x;
                            colour  <= COL_DRAW;
                        end else begin
                            idx_r  <= idx_nxt_s;
                            plot_x <= old_x_r + {2'b00, idx_nxt_s};
                        end
                    end else begin
                        plot_valid <= plot_valid;
                    end
                end
                ST_DRAW: begin
                    if (plot_valid && plot_ready) begin
                        if (idx_r == IDX_LAST) begin
                            state_r    <= ST_IDLE;
                            idx_r      <= 6'd0;
                            plot_valid <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            idx_r  <= idx_nxt_s;
                            plot_x <= paddle_x + {2'b00, idx_nxt_s};
                        end
                    end else begin
                        plot_valid <= plot_valid;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    plot_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef PADDLE_ACCEL_EN
    // Count consecutive accepted same-direction ticks; any break restarts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_r <= 3'd0;
            hold_dir_r <= 1'b0;
        end else if (!move_left_s && !move_right_s) begin
            hold_cnt_r <= 3'd0;
        end else if ((state_r == ST_IDLE) && pending_r) begin
            hold_cnt_r <= 3'd0;
        end else if (tick_s && (state_r == ST_IDLE)) begin
            hold_dir_r <= move_right_s;
            if ((new_x_s == paddle_x) ||
                (move_left_s && (new_x_s == X_MIN_8)) ||
                (move_right_s && (new_x_s == X_MAX_8))) begin
                hold_cnt_r <= 3'd0;
            end else if ((hold_cnt_r != 3'd0) && (hold_dir_r == move_right_s)) begin
                hold_cnt_r <= (hold_cnt_r == 3'd7) ? 3'd7 : (hold_cnt_r + 3'd1);
            end else begin
                hold_cnt_r <= 3'd1;
            end
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_paddle_ctrl_p.sv
// Self-checking bench for paddle_ctrl_p: scoreboard of expected plot words,
// a table of single-move vectors, and hand-written multi-cycle sequences.
module tb_paddle_ctrl_p;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_left;
    logic       key_right;
    logic       game_over;
    logic [6:0] ball_y;
    logic       plot_ready;
    logic [7:0] paddle_x;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] colour;
    logic       plot_valid;
    logic       busy;

    logic       key_right2;
    logic [7:0] paddle_x2;
    logic [7:0] plot_x2;
    logic [6:0] plot_y2;
    logic [2:0] colour2;
    logic       plot_valid2;
    logic       busy2;

    typedef struct {
        logic [7:0] x;
        logic [2:0] c;
    } word_t;

    typedef struct {
        logic kl;
        logic kr;
        int   exp_x;
    } vec_t;

    word_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    xfer_cnt = 0;
    int    xfer2 = 0;
    int    busy_cycles = 0;
    int    stall_cnt = 0;
    int    model_x = 60;
    bit    stall_seen = 1'b0;
    int    held_x;
    int    held_c;

    always #5 clock = ~clock;

    paddle_ctrl_p #(.TICK_DIV(4)) dut (
        .clock(clock), .reset(reset), .key_left(key_left), .key_right(key_right),
        .game_over(game_over), .ball_y(ball_y), .paddle_x(paddle_x), .plot_x(plot_x),
        .plot_y(plot_y), .colour(colour), .plot_valid(plot_valid),
        .plot_ready(plot_ready), .busy(busy)
    );

    paddle_ctrl_p #(.TICK_DIV(4), .STEP(4), .X_START(102)) dut_sat (
        .clock(clock), .reset(reset), .key_left(1'b1), .key_right(key_right2),
        .game_over(1'b0), .ball_y(7'd0), .paddle_x(paddle_x2), .plot_x(plot_x2),
        .plot_y(plot_y2), .colour(colour2), .plot_valid(plot_valid2),
        .plot_ready(1'b1), .busy(busy2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_span(input int x0, input logic [2:0] c);
        word_t w;
        for (int i = 0; i < 25; i++) begin
            w.x = 8'(x0 + i);
            w.c = c;
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (((exp_q.size() != 0) || busy) && (n < limit)) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL %s_timeout: got busy=%0d queued=%0d expected idle",
                     name, busy, exp_q.size());
        end
    endtask

    // Drive keys until the model's target is reached; keep=1 holds past it.
    task automatic run_move(input string name, input logic kl, input logic kr,
                            input int target, input bit keep);
        int n;
        int nx;
        int first_nx;
        int lim;
        int cnt;
        bit seen;
        n = 0;
        first_nx = model_x;
        while (model_x != target) begin
            nx = (target > model_x) ? model_x + 1 : model_x - 1;
            if (n == 0) first_nx = nx;
            push_span(model_x, 3'b000);
            push_span(nx, 3'b111);
            model_x = nx;
            n++;
        end
        busy_cycles = 0;
        key_left = kl;
        key_right = kr;
        if (n == 0) begin
            cyc(12);
            check({name, "_no_redraw"}, busy_cycles, 0);
        end else begin
            lim = n * 60 + 40;
            cnt = 0;
            seen = 1'b0;
            while ((exp_q.size() >= 50) && (cnt < lim)) begin
                if (busy && !seen) begin
                    seen = 1'b1;
                    check({name, "_first_valid"}, plot_valid, 1);
                    check({name, "_first_x"}, paddle_x, first_nx);
                end
                cyc(1);
                cnt++;
            end
            if (!keep) begin
                key_left = 1'b1;
                key_right = 1'b1;
            end
            wait_idle(name, lim);
            if (n == 1) check({name, "_busy_len"}, busy_cycles, 50);
            if (keep) begin
                busy_cycles = 0;
                cyc(40);
                check({name, "_bound_no_redraw"}, busy_cycles, 0);
            end
        end
        key_left = 1'b1;
        key_right = 1'b1;
        check({name, "_paddle_x"}, paddle_x, target);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clock) begin
        word_t w;
        if (busy) busy_cycles++;
        if (plot_valid2) xfer2++;
        if (stall_seen) begin
            check("stall_hold_x", plot_x, held_x);
            check("stall_hold_colour", colour, held_c);
        end
        stall_seen = 1'b0;
        if (plot_valid && !plot_ready) begin
            stall_seen = 1'b1;
            stall_cnt++;
            held_x = plot_x;
            held_c = colour;
        end
        if (plot_valid && plot_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got x=%0d colour=%0d expected none",
                         plot_x, colour);
            end else begin
                w = exp_q.pop_front();
                check("word_x", plot_x, w.x);
                check("word_colour", colour, w.c);
                check("word_y", plot_y, 119);
            end
        end
    end

    initial begin
        vec_t vecs[6];
        int   cnt;
        vecs[0] = '{kl: 1'b1, kr: 1'b0, exp_x: 61};
        vecs[1] = '{kl: 1'b0, kr: 1'b1, exp_x: 60};
        vecs[2] = '{kl: 1'b0, kr: 1'b0, exp_x: 60};
        vecs[3] = '{kl: 1'b1, kr: 1'b1, exp_x: 60};
        vecs[4] = '{kl: 1'b0, kr: 1'b1, exp_x: 59};
        vecs[5] = '{kl: 1'b1, kr: 1'b0, exp_x: 60};

        reset = 1'b1;
        key_left = 1'b1;
        key_right = 1'b1;
        key_right2 = 1'b1;
        game_over = 1'b0;
        ball_y = 7'd0;
        plot_ready = 1'b1;
        cyc(3);
        check("rst_paddle_x", paddle_x, 60);
        check("rst_plot_x", plot_x, 0);
        check("rst_plot_y", plot_y, 119);
        check("rst_colour", colour, 0);
        check("rst_plot_valid", plot_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_paddle_x_sat", paddle_x2, 102);

        // Initial draw only, no erase.
        push_span(60, 3'b111);
        xfer_cnt = 0;
        reset = 1'b0;
        wait_idle("init", 100);
        check("init_xfers", xfer_cnt, 25);
        check("init_paddle_x", paddle_x, 60);

        // Saturation in a single large step, then no further redraw.
        xfer2 = 0;
        key_right2 = 1'b0;
        cyc(150);
        check("sat_paddle_x", paddle_x2, 103);
        check("sat_xfers", xfer2, 50);
        check("sat_busy", busy2, 0);
        key_right2 = 1'b1;

        // Table of single-move vectors.
        for (int i = 0; i < 6; i++) begin
            run_move($sformatf("vec%0d", i), vecs[i].kl, vecs[i].kr, vecs[i].exp_x, 1'b0);
        end

        // Backpressure stall during erase plus ticks arriving while busy.
        push_span(60, 3'b000);
        push_span(61, 3'b111);
        model_x = 61;
        xfer_cnt = 0;
        stall_cnt = 0;
        key_right = 1'b0;
        cnt = 0;
        while (!busy && (cnt < 20)) begin
            cyc(1);
            cnt++;
        end
        check("stall_busy_rise", busy, 1);
        cyc(3);
        plot_ready = 1'b0;
        cyc(2);
        plot_ready = 1'b1;
        cyc(12);
        check("tick_while_busy_x", paddle_x, 61);
        key_right = 1'b1;
        wait_idle("stall", 200);
        check("stall_xfers", xfer_cnt, 50);
        check("stall_cycles", stall_cnt, 2);
        check("stall_paddle_x", paddle_x, 61);

        // Hold left down to the lower bound, then keep holding.
        run_move("left_hold", 1'b0, 1'b1, 15, 1'b1);
        run_move("right_to_90", 1'b1, 1'b0, 90, 1'b0);

        // Restart from x=90.
        push_span(90, 3'b000);
        push_span(60, 3'b111);
        model_x = 60;
        game_over = 1'b1;
        ball_y = 7'd116;
        cyc(1);
        game_over = 1'b0;
        ball_y = 7'd0;
        wait_idle("restart", 200);
        check("restart_paddle_x", paddle_x, 60);

        // ball_y exactly 115 does not restart.
        busy_cycles = 0;
        game_over = 1'b1;
        ball_y = 7'd115;
        cyc(1);
        game_over = 1'b0;
        ball_y = 7'd0;
        cyc(12);
        check("no_restart_busy", busy_cycles, 0);
        check("no_restart_x", paddle_x, 60);

        // Restart while already at X_START still redraws.
        push_span(60, 3'b000);
        push_span(60, 3'b111);
        game_over = 1'b1;
        ball_y = 7'd127;
        cyc(1);
        game_over = 1'b0;
        ball_y = 7'd0;
        wait_idle("restart_same", 200);
        check("restart_same_x", paddle_x, 60);

        // Reset in the middle of a redraw aborts it.
        push_span(60, 3'b000);
        push_span(61, 3'b111);
        key_right = 1'b0;
        cnt = 0;
        while (!busy && (cnt < 20)) begin
            cyc(1);
            cnt++;
        end
        cyc(5);
        key_right = 1'b1;
        reset = 1'b1;
        cyc(1);
        check("midrst_valid", plot_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_x", paddle_x, 60);
        exp_q.delete();
        model_x = 60;
        push_span(60, 3'b111);
        cyc(1);
        reset = 1'b0;
        wait_idle("midrst_init", 100);
        check("midrst_final_x", paddle_x, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
